// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and enums for the CPU bus controller.
package mem_map_pkg;

    localparam int unsigned LCD_DATA_ADDR = 32'h0000_F000;
    localparam int unsigned LCD_CTRL_ADDR = 32'h0000_F001;
    localparam int unsigned INT_EN_ADDR   = 32'h0000_FFF0;
    localparam int unsigned INT_VEC_BASE  = 32'h0000_FF00;

    // Target selected by the latched address
    typedef enum logic [2:0] {
        REG_ROM,
        REG_STACK,
        REG_LCD,
        REG_INT,
        REG_NONE
    } region_t;

    // Bus access sequencing
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mmio_regs.sv
// LCD and interrupt-vector register bank: address match, write strobe, read mux.
module mmio_regs
    import mem_map_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int INT_CHANNELS = 4
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic                        i_wr_stb,
    output logic                        o_hit_lcd,
    output logic                        o_hit_int,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [10:0]                 o_lcd_pins,
    output logic [32*INT_CHANNELS-1:0]  o_int_addr,
    output logic [INT_CHANNELS-1:0]     o_int_en
);

    // Only the enable bits that fit in one bus word are reachable
    localparam int EN_VIS = (INT_CHANNELS < DATA_W) ? INT_CHANNELS : DATA_W;

    logic                          w_is_lcd_d;
    logic                          w_is_lcd_c;
    logic                          w_is_en;
    logic                          w_in_vec;
    logic [ADDR_W-1:0]             w_vec_off;
    logic [INT_CHANNELS-1:0][15:0] w_vec_rd;

    logic [7:0]                    r_lcd_data;
    logic [2:0]                    r_lcd_ctrl;
    logic [INT_CHANNELS-1:0]       r_int_en;

    assign w_is_lcd_d = (i_addr == ADDR_W'(LCD_DATA_ADDR));
    assign w_is_lcd_c = (i_addr == ADDR_W'(LCD_CTRL_ADDR));
    assign w_is_en    = (i_addr == ADDR_W'(INT_EN_ADDR));
    // Offset into the vector window; the lower-bound test stops wrap-around hits
    assign w_vec_off  = i_addr - ADDR_W'(INT_VEC_BASE);
    assign w_in_vec   = (i_addr >= ADDR_W'(INT_VEC_BASE)) &&
                        (w_vec_off < ADDR_W'(2 * INT_CHANNELS));

    assign o_hit_lcd  = w_is_lcd_d | w_is_lcd_c;
    assign o_hit_int  = w_is_en | w_in_vec;
    assign o_lcd_pins = {r_lcd_ctrl, r_lcd_data};
    assign o_int_en   = r_int_en;

    // LCD data/control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcd_data <= '0;
            r_lcd_ctrl <= '0;
        end else if (i_wr_stb) begin
            if (w_is_lcd_d) r_lcd_data <= i_wdata[7:0];
            if (w_is_lcd_c) r_lcd_ctrl <= i_wdata[2:0];
        end
    end

    // Interrupt enable mask, all channels enabled out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_en <= '1;
        end else if (i_wr_stb && w_is_en) begin
            for (int k = 0; k < EN_VIS; k++) begin
                r_int_en[k] <= i_wdata[k];
            end
        end
    end

    // One 32-bit vector per channel, written as two 16-bit halves
    for (genvar gi = 0; gi < INT_CHANNELS; gi++) begin : g_vec
        logic        w_sel_lo;
        logic        w_sel_hi;
        logic [31:0] r_vec;

        assign w_sel_lo = w_in_vec && (w_vec_off == ADDR_W'(2 * gi));
        assign w_sel_hi = w_in_vec && (w_vec_off == ADDR_W'(2 * gi + 1));

        // Half-word update of this channel's vector
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vec <= '0;
            end else if (i_wr_stb && w_sel_lo) begin
                r_vec[15:0] <= i_wdata[15:0];
            end else if (i_wr_stb && w_sel_hi) begin
                r_vec[31:16] <= i_wdata[15:0];
            end
        end

        assign w_vec_rd[gi] = w_sel_lo ? r_vec[15:0] :
                              w_sel_hi ? r_vec[31:16] : 16'h0000;
        assign o_int_addr[32*gi +: 32] = r_vec;
    end

    // Readback mux, zero-extended to the bus width
    always_comb begin
        o_rdata = '0;
        if (w_is_lcd_d) begin
            o_rdata[7:0] = r_lcd_data;
        end else if (w_is_lcd_c) begin
            o_rdata[2:0] = r_lcd_ctrl;
        end else if (w_is_en) begin
            for (int k = 0; k < EN_VIS; k++) begin
                o_rdata[k] = r_int_en[k];
            end
        end else begin
            for (int k = 0; k < INT_CHANNELS; k++) begin
                o_rdata[15:0] = o_rdata[15:0] | w_vec_rd[k];
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU bus memory-map controller: decodes ROM, downward stack, MMIO or unmapped,
// completing every access with a wait-stated ready pulse.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int ROM_DEPTH    = 1024,
    parameter int STACK_TOP    = 'hD000,
    parameter int STACK_DEPTH  = 1024,
    parameter int WAIT_STATES  = 1,
    parameter int INT_CHANNELS = 4
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        we,
    input  logic                        re,
    output logic [DATA_W-1:0]           rdata,
    output logic                        ready,
    output logic                        busErr,
    output logic [10:0]                 lcdPins,
    output logic [32*INT_CHANNELS-1:0]  intAddr,
    output logic [INT_CHANNELS-1:0]     intEn
);

    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int STK_AW = $clog2(STACK_DEPTH);

    // Program image; replace with the firmware contents for a real build
    localparam logic [DATA_W-1:0] ROM_IMAGE [ROM_DEPTH] = '{default: '0};

    if (ROM_DEPTH > STACK_TOP - STACK_DEPTH + 1) begin : g_chk_overlap
        $error("mem_bus_ctrl: ROM region overlaps stack region");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_chk_wait
        $error("mem_bus_ctrl: WAIT_STATES must be 0..15");
    end
    if (INT_CHANNELS < 1 || INT_CHANNELS > 64) begin : g_chk_chan
        $error("mem_bus_ctrl: INT_CHANNELS must be 1..64");
    end
    if (DATA_W < 16) begin : g_chk_data
        $error("mem_bus_ctrl: DATA_W must hold a 16-bit vector half");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic [DATA_W-1:0]   r_stack [STACK_DEPTH];
    logic [DATA_W-1:0]   r_rom_q;
    logic [DATA_W-1:0]   r_stk_q;

    logic                w_accept;
    logic                w_commit;
    logic                w_dec;
    logic                w_done;
    region_t             w_region;
    logic                w_fault;
    logic [DATA_W-1:0]   w_rd_mux;
    logic                w_stk_wr;
    logic                w_mmio_wr;
    logic [STK_AW-1:0]   w_stk_rd_idx;
    logic [STK_AW-1:0]   w_stk_wr_idx;
    logic                w_hit_lcd;
    logic                w_hit_int;
    logic [DATA_W-1:0]   w_mmio_rdata;

    // Stack grows down: STACK_TOP is word 0
    assign w_stk_rd_idx = STK_AW'(STACK_TOP) - addr[STK_AW-1:0];
    assign w_stk_wr_idx = STK_AW'(STACK_TOP) - r_addr[STK_AW-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; requests outside IDLE are ignored
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (we || re)       w_state_next = ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0)  w_state_next = ST_DONE;
            ST_DONE:                     w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded control strobes
    always_comb begin
        w_accept = 1'b0;
        w_commit = 1'b0;
        w_dec    = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = we | re;
            ST_WAIT: begin
                w_commit = (r_cnt == 4'd0);
                w_dec    = (r_cnt != 4'd0);
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    // Region decode on the latched address, ROM > stack > MMIO
    always_comb begin
        w_region = REG_NONE;
        if (r_addr < ADDR_W'(ROM_DEPTH)) begin
            w_region = REG_ROM;
        end else if ((r_addr <= ADDR_W'(STACK_TOP)) &&
                     (r_addr >  ADDR_W'(STACK_TOP - STACK_DEPTH))) begin
            w_region = REG_STACK;
        end else if (w_hit_lcd) begin
            w_region = REG_LCD;
        end else if (w_hit_int) begin
            w_region = REG_INT;
        end
    end

    // Completion data and fault for the latched access
    always_comb begin
        w_fault  = (w_region == REG_NONE) || ((w_region == REG_ROM) && r_we);
        w_rd_mux = '0;
        case (w_region)
            REG_ROM:           w_rd_mux = r_rom_q;
            REG_STACK:         w_rd_mux = r_stk_q;
            REG_LCD, REG_INT:  w_rd_mux = w_mmio_rdata;
            default:           w_rd_mux = '0;
        endcase
    end

    assign w_stk_wr  = w_commit && r_we && (w_region == REG_STACK);
    assign w_mmio_wr = w_commit && r_we && ((w_region == REG_LCD) || (w_region == REG_INT));

    // Request latch, wait countdown and completion result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= we;
                r_cnt   <= 4'(WAIT_STATES);
            end else if (w_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err <= w_fault;
                if (!r_we) r_rdata <= w_rd_mux;
            end
        end
    end

    // Synchronous ROM/stack reads issued on acceptance, stack write on completion
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rom_q <= ROM_IMAGE[addr[ROM_AW-1:0]];
            r_stk_q <= r_stack[w_stk_rd_idx];
        end
        if (w_stk_wr) begin
            r_stack[w_stk_wr_idx] <= r_wdata;
        end
    end

    mmio_regs #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .INT_CHANNELS (INT_CHANNELS)
    ) u_mmio (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (r_addr),
        .i_wdata    (r_wdata),
        .i_wr_stb   (w_mmio_wr),
        .o_hit_lcd  (w_hit_lcd),
        .o_hit_int  (w_hit_int),
        .o_rdata    (w_mmio_rdata),
        .o_lcd_pins (lcdPins),
        .o_int_addr (intAddr),
        .o_int_en   (intEn)
    );

    assign ready  = w_done;
    assign busErr = w_done & r_err;
    assign rdata  = r_rdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised bench for mem_bus_ctrl with an address-map level reference model.
module tb_mem_bus_ctrl;

    localparam int     AW      = 33;
    localparam int     DW      = 16;
    localparam int     WS      = 1;
    localparam int     NCH     = 4;
    localparam longint ROM_D   = 1024;
    localparam longint STK_TOP = 'hD000;
    localparam longint STK_DEP = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              we;
    logic              re;
    logic [DW-1:0]     rdata;
    logic              ready;
    logic              busErr;
    logic [10:0]       lcdPins;
    logic [32*NCH-1:0] intAddr;
    logic [NCH-1:0]    intEn;

    always #5 clk = ~clk;

    mem_bus_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(1024), .STACK_TOP('hD000),
        .STACK_DEPTH(1024), .WAIT_STATES(WS), .INT_CHANNELS(NCH)
    ) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .ready(ready), .busErr(busErr), .lcdPins(lcdPins),
        .intAddr(intAddr), .intEn(intEn)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model (address-map view) ----------------
    logic [15:0] m_stk [1024];
    logic [7:0]  m_lcd_d;
    logic [2:0]  m_lcd_c;
    logic [3:0]  m_ien;
    logic [31:0] m_vec [NCH];
    logic [15:0] m_rd;

    function automatic void m_reset();
        m_lcd_d = 8'h00;
        m_lcd_c = 3'h0;
        m_ien   = 4'hF;
        for (int k = 0; k < NCH; k++) m_vec[k] = 32'h0;
        m_rd    = 16'h0;
    endfunction

    function automatic void predict(input logic [AW-1:0] a, input bit w,
                                    output bit err, output logic [15:0] rd);
        longint ua = longint'(a);
        err = 1'b0;
        rd  = 16'h0;
        if (ua < ROM_D)                                  err = w;
        else if (ua <= STK_TOP && ua > STK_TOP - STK_DEP) rd = m_stk[STK_TOP - ua];
        else if (ua == 'hF000)                           rd = {8'h00, m_lcd_d};
        else if (ua == 'hF001)                           rd = {13'h0, m_lcd_c};
        else if (ua == 'hFFF0)                           rd = {12'h0, m_ien};
        else if (ua >= 'hFF00 && ua < 'hFF00 + 2 * NCH)
            rd = ((ua - 'hFF00) % 2 == 1) ? m_vec[(ua - 'hFF00) / 2][31:16]
                                          : m_vec[(ua - 'hFF00) / 2][15:0];
        else                                             err = 1'b1;
    endfunction

    function automatic void apply_write(input logic [AW-1:0] a, input logic [15:0] wd);
        longint ua = longint'(a);
        if (ua < ROM_D) ;
        else if (ua <= STK_TOP && ua > STK_TOP - STK_DEP) m_stk[STK_TOP - ua] = wd;
        else if (ua == 'hF000) m_lcd_d = wd[7:0];
        else if (ua == 'hF001) m_lcd_c = wd[2:0];
        else if (ua == 'hFFF0) m_ien   = wd[3:0];
        else if (ua >= 'hFF00 && ua < 'hFF00 + 2 * NCH) begin
            if ((ua - 'hFF00) % 2 == 1) m_vec[(ua - 'hFF00) / 2][31:16] = wd;
            else                        m_vec[(ua - 'hFF00) / 2][15:0]  = wd;
        end
    endfunction

    // Outstanding access as seen by the model
    bit            pend = 1'b0;
    int            pend_cyc;
    bit            pend_w;
    bit            pend_err;
    logic [15:0]   pend_rd;
    logic [15:0]   pend_wd;
    logic [AW-1:0] pend_a;

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_reset();
                pend = 1'b0;
                chk("reset_ready", ready, 1'b0);
                chk("reset_busErr", busErr, 1'b0);
            end else if (pend && cyc == pend_cyc) begin
                chk("ready_pulse", ready, 1'b1);
                chk("busErr", busErr, pend_err);
                if (pend_w) apply_write(pend_a, pend_wd);
                else        m_rd = pend_rd;
                pend = 1'b0;
            end else begin
                chk("ready_quiet", ready, 1'b0);
                chk("busErr_quiet", busErr, 1'b0);
            end
            chk("rdata", rdata, m_rd);
            chk("lcdPins", lcdPins, {m_lcd_c, m_lcd_d});
            chk("intEn", intEn, m_ien);
            chk("intAddr", intAddr, {m_vec[3], m_vec[2], m_vec[1], m_vec[0]});
        end
    end

    // One bus access; holds the request until ready unless told to drop it early
    task automatic txn(input logic [AW-1:0] a, input logic [15:0] wd, input bit w,
                       input bit r, input bit drop,
                       output logic [15:0] rd, output bit err, output int lat);
        bit          pe;
        logic [15:0] pr;
        int          start;
        @(negedge clk); #1;
        addr = a; wdata = wd; we = w; re = r;
        predict(a, w, pe, pr);
        pend_a = a; pend_wd = wd; pend_w = w; pend_err = pe; pend_rd = pr;
        start = cyc;
        pend_cyc = cyc + 2 + WS;
        pend = 1'b1;
        for (int i = 0; i < 40 && pend; i++) begin
            @(negedge clk); #1;
            if (drop && i == 0) begin
                we = 1'b0; re = 1'b0;
                addr = {1'b0, 32'($urandom)};
                wdata = 16'($urandom);
            end
        end
        if (pend) begin
            n_total++;
            $display("FAIL ready_timeout: no ready for addr %0h within 40 cycles", a);
            pend = 1'b0;
        end
        rd  = rdata;
        err = busErr;
        lat = cyc - start;
        we = 1'b0; re = 1'b0;
        $display("txn addr=%0h we=%0b re=%0b wdata=%0h -> rdata=%0h busErr=%0b lat=%0d",
                 a, w, r, wd, rd, err, lat);
    endtask

    function automatic logic [AW-1:0] stk_slot(input int i);
        int idx = (i < 16) ? i : ('h3F0 + i - 16);
        return AW'(STK_TOP - idx);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0]   rd;
    bit            err;
    int            lat;
    logic [AW-1:0] ra;
    logic [AW-1:0] bnd [6];

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_ready", ready, 1'b0);
        chk("idle_intEn", intEn, 4'b1111);
        chk("idle_intAddr", intAddr, 128'h0);
        chk("idle_lcdPins", lcdPins, 11'h000);

        // Stack
        txn(33'h0_0000_D000, 16'h1234, 1, 0, 0, rd, err, lat);
        chk("wr_latency", lat, 3);
        txn(33'h0_0000_D000, 16'h0000, 0, 1, 0, rd, err, lat);
        chk("stack_top_read", rd, 16'h1234);
        txn(33'h0_0000_CC01, 16'h5A5A, 1, 0, 1, rd, err, lat);
        txn(33'h0_0000_CC01, 16'h0000, 0, 1, 0, rd, err, lat);
        chk("stack_bottom_read", rd, 16'h5A5A);
        txn(33'h0_0000_C000, 16'h0000, 0, 1, 0, rd, err, lat);
        chk("unmapped_err", err, 1'b1);
        chk("unmapped_rdata", rd, 16'h0000);

        // LCD
        txn(33'h0_0000_F000, 16'h00AB, 1, 0, 0, rd, err, lat);
        txn(33'h0_0000_F001, 16'h0005, 1, 0, 0, rd, err, lat);
        chk("lcd_pins", lcdPins, 11'h5AB);
        txn(33'h0_0000_F001, 16'h0000, 0, 1, 0, rd, err, lat);
        chk("lcd_ctrl_read", rd, 16'h0005);
        txn(33'h0_0000_F000, 16'h0077, 1, 1, 0, rd, err, lat);
        chk("we_wins_lcd", lcdPins[7:0], 8'h77);
        chk("we_wins_rdata", rd, 16'h0005);

        // Interrupt vectors and mask
        txn(33'h0_0000_FF04, 16'hBEEF, 1, 0, 0, rd, err, lat);
        txn(33'h0_0000_FF05, 16'h0001, 1, 0, 0, rd, err, lat);
        chk("vec2", intAddr[95:64], 32'h0001_BEEF);
        txn(33'h0_0000_FFF0, 16'h0002, 1, 0, 0, rd, err, lat);
        chk("int_mask", intEn, 4'b0010);
        txn(33'h0_0000_FF08, 16'h1111, 1, 0, 0, rd, err, lat);
        chk("vec_slot4_err", err, 1'b1);

        // ROM and full-width decode
        txn(33'h0_0000_0010, 16'hDEAD, 1, 0, 0, rd, err, lat);
        chk("rom_write_err", err, 1'b1);
        txn(33'h0_0000_0010, 16'h0000, 0, 1, 0, rd, err, lat);
        chk("rom_read_err", err, 1'b0);
        chk("rom_read_data", rd, 16'h0000);
        txn(33'h1_0000_D000, 16'h0000, 0, 1, 0, rd, err, lat);
        chk("bit32_err", err, 1'b1);

        // Reset while a LCD write is waiting
        @(negedge clk); #1;
        addr = 33'h0_0000_F000; wdata = 16'h00CD; we = 1'b1;
        @(negedge clk); #1;
        rst = 1'b1; we = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_lcdPins", lcdPins, 11'h000);
        chk("abort_intEn", intEn, 4'b1111);

        // Warm up every stack slot used by the random phase
        for (int i = 0; i < 32; i++)
            txn(stk_slot(i), 16'($urandom), 1, 0, 0, rd, err, lat);

        bnd[0] = 33'h0_0000_CC00; bnd[1] = 33'h0_0000_03FF; bnd[2] = 33'h0_0000_0400;
        bnd[3] = 33'h0_0000_D001; bnd[4] = 33'h0_0000_FEFF; bnd[5] = 33'h0_0000_FF07;

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 7))
                0:       ra = AW'($urandom_range(0, 1023));
                1, 2:    ra = stk_slot($urandom_range(0, 31));
                3:       ra = AW'('hF000 + $urandom_range(0, 1));
                4:       ra = AW'('hFFF0);
                5:       ra = AW'('hFF00 + $urandom_range(0, 15));
                6:       ra = {1'b1, 32'($urandom_range(0, 'hFFFF))};
                default: ra = bnd[$urandom_range(0, 5)];
            endcase
            begin
                bit w  = 1'($urandom_range(0, 1));
                bit r  = w ? 1'($urandom_range(0, 1)) : 1'b1;
                bit dr = 1'($urandom_range(0, 1));
                txn(ra, 16'($urandom), w, r, dr, rd, err, lat);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
